// File: rtl/keyed_lut_cam.sv
// keyed_lut_cam: run-time loadable associative key->data table with a one-stage
// valid/ready lookup pipeline returning data, hit flag and matching entry index.
module keyed_lut_cam #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 8,
  parameter int HAS_DEFAULT = 1,
  localparam int IDX_W      = NR_KEY > 1 ? $clog2(NR_KEY) : 1,
  localparam int CNT_W      = $clog2(NR_KEY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                lk_valid,
  output logic                lk_ready,
  input  logic [KEY_LEN-1:0]  lk_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic [CNT_W-1:0]    occupancy,
  output logic                full
);
  logic [NR_KEY-1:0]   r_valid;
  logic [KEY_LEN-1:0]  r_key [NR_KEY];
  logic [DATA_LEN-1:0] r_data [NR_KEY];
  logic [IDX_W-1:0]    r_vptr;
  logic [CNT_W-1:0]    r_occ;
  logic                r_rsp_valid;
  logic [DATA_LEN-1:0] r_rsp_data;
  logic                r_rsp_hit;
  logic [IDX_W-1:0]    r_rsp_idx;
  logic                w_lk_hit;
  logic [IDX_W-1:0]    w_lk_idx;
  logic [DATA_LEN-1:0] w_lk_data;
  logic                w_wr_hit;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_free_idx;
  logic                w_accept;
  // Descending scans so the lowest matching/free index is the one that sticks.
  always_comb begin
    w_lk_hit   = 1'b0;
    w_lk_idx   = '0;
    w_wr_hit   = 1'b0;
    w_wr_idx   = '0;
    w_free_idx = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (r_valid[i] && r_key[i] == lk_key) begin
        w_lk_hit = 1'b1;
        w_lk_idx = IDX_W'(i);
      end
      if (r_valid[i] && r_key[i] == wr_key) begin
        w_wr_hit = 1'b1;
        w_wr_idx = IDX_W'(i);
      end
      if (!r_valid[i]) w_free_idx = IDX_W'(i);
    end
    w_lk_data = w_lk_hit ? r_data[w_lk_idx] : (HAS_DEFAULT != 0 ? default_out : '0);
  end
  assign full      = r_occ == CNT_W'(NR_KEY);
  assign occupancy = r_occ;
  assign lk_ready  = !r_rsp_valid || rsp_ready;
  assign w_accept  = lk_valid && lk_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_hit   = r_rsp_hit;
  assign rsp_idx   = r_rsp_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_vptr      <= '0;
      r_occ       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
    end else begin
      if (flush) begin
        r_valid <= '0;
        r_vptr  <= '0;
        r_occ   <= '0;
      end else if (wr_en) begin
        if (w_wr_hit) begin
          r_data[w_wr_idx] <= wr_data;
        end else if (!full) begin
          r_valid[w_free_idx] <= 1'b1;
          r_key[w_free_idx]   <= wr_key;
          r_data[w_free_idx]  <= wr_data;
          r_occ               <= r_occ + 1'b1;
        end else begin
          r_key[r_vptr]  <= wr_key;
          r_data[r_vptr] <= wr_data;
          r_vptr         <= r_vptr == IDX_W'(NR_KEY - 1) ? '0 : r_vptr + 1'b1;
        end
      end
      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_lk_data;
        r_rsp_hit   <= w_lk_hit;
        r_rsp_idx   <= w_lk_idx;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_keyed_lut_cam.sv
// tb_keyed_lut_cam: directed plus short random checks of keyed_lut_cam against a
// behavioural table model with a response scoreboard (HAS_DEFAULT=1 and =0 instances).
module tb_keyed_lut_cam;
  logic       clk = 1'b0;
  logic       rst, flush, wr_en, lk_valid, rsp_ready;
  logic [3:0] wr_key, lk_key;
  logic [7:0] wr_data, default_out;
  logic       lk_ready, rsp_valid, rsp_hit, full;
  logic [7:0] rsp_data;
  logic [1:0] rsp_idx;
  logic [2:0] occupancy;
  logic       lk_ready0, rsp_valid0, rsp_hit0, full0;
  logic [7:0] rsp_data0;
  logic [1:0] rsp_idx0;
  logic [2:0] occupancy0;
  int n_tot = 0, n_pass = 0;

  always #5 clk = ~clk;

  keyed_lut_cam #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key), .default_out(default_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .rsp_idx(rsp_idx), .occupancy(occupancy), .full(full));

  keyed_lut_cam #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(8), .HAS_DEFAULT(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
    .lk_valid(lk_valid), .lk_ready(lk_ready0), .lk_key(lk_key), .default_out(default_out),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0), .rsp_hit(rsp_hit0),
    .rsp_idx(rsp_idx0), .occupancy(occupancy0), .full(full0));

  typedef struct {
    logic       hit;
    logic [1:0] idx;
    logic [7:0] d;
    logic [7:0] d0;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [3:0] m_valid;
  logic [3:0] m_key [4];
  logic [7:0] m_data [4];
  int         m_ptr, m_occ;
  logic       m_rsp_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t m_lookup(input logic [3:0] key);
    exp_t e;
    e.hit = 1'b0; e.idx = 2'd0; e.d = default_out; e.d0 = 8'h00;
    for (int i = 0; i < 4; i++)
      if (!e.hit && m_valid[i] && m_key[i] == key) begin
        e.hit = 1'b1; e.idx = 2'(i); e.d = m_data[i]; e.d0 = m_data[i];
      end
    return e;
  endfunction

  task automatic m_write(input logic [3:0] key, input logic [7:0] data);
    int slot;
    slot = -1;
    for (int i = 0; i < 4; i++)
      if (slot < 0 && m_valid[i] && m_key[i] == key) slot = i;
    if (slot >= 0) begin
      m_data[slot] = data;
    end else if (m_occ < 4) begin
      for (int i = 3; i >= 0; i--) if (!m_valid[i]) slot = i;
      m_valid[slot] = 1'b1; m_key[slot] = key; m_data[slot] = data; m_occ++;
    end else begin
      m_key[m_ptr] = key; m_data[m_ptr] = data; m_ptr = (m_ptr + 1) % 4;
    end
  endtask

  task automatic tick();
    logic acc, was_rst;
    #1;
    chk("lk_ready", lk_ready, !m_rsp_valid || rsp_ready);
    chk("lk_ready0", lk_ready0, !m_rsp_valid || rsp_ready);
    was_rst = rst;
    acc = lk_valid && (!m_rsp_valid || rsp_ready);
    if (rst) begin
      m_valid = '0; m_ptr = 0; m_occ = 0; m_rsp_valid = 1'b0; q.delete();
      cur = '{hit: 1'b0, idx: 2'd0, d: 8'h00, d0: 8'h00};
    end else begin
      if (acc) q.push_back(m_lookup(lk_key));
      if (flush) begin
        m_valid = '0; m_ptr = 0; m_occ = 0;
      end else if (wr_en) begin
        m_write(wr_key, wr_data);
      end
      m_rsp_valid = acc ? 1'b1 : (rsp_ready ? 1'b0 : m_rsp_valid);
    end
    @(posedge clk); #1;
    if (!was_rst && acc) cur = q.pop_front();
    chk("rsp_valid", rsp_valid, m_rsp_valid);
    chk("rsp_valid0", rsp_valid0, m_rsp_valid);
    if (m_rsp_valid || was_rst) begin
      chk("rsp_hit", rsp_hit, cur.hit);
      chk("rsp_idx", rsp_idx, cur.idx);
      chk("rsp_data", rsp_data, cur.d);
      chk("rsp_data0", rsp_data0, cur.d0);
    end
    chk("occupancy", occupancy, m_occ);
    chk("full", full, m_occ == 4);
    chk("occupancy0", occupancy0, m_occ);
  endtask

  task automatic wr(input logic [3:0] k, input logic [7:0] d);
    wr_en = 1'b1; wr_key = k; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic lk(input logic [3:0] k);
    lk_valid = 1'b1; lk_key = k; tick(); lk_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_key = '0; wr_data = '0;
    lk_valid = 1'b0; lk_key = '0; rsp_ready = 1'b1; default_out = 8'hEE;
    m_valid = '0; m_ptr = 0; m_occ = 0; m_rsp_valid = 1'b0;
    cur = '{hit: 1'b0, idx: 2'd0, d: 8'h00, d0: 8'h00};
    tick(); tick();
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_occ", occupancy, 3'd0);
    rst = 1'b0;
    wr(4'd1, 8'h11);
    wr(4'd2, 8'h22);
    lk(4'd2);
    chk("lk2_hit", rsp_hit, 1'b1);
    chk("lk2_idx", rsp_idx, 2'd1);
    chk("lk2_data", rsp_data, 8'h22);
    chk("lk2_occ", occupancy, 3'd2);
    lk(4'd7);
    chk("miss_hit", rsp_hit, 1'b0);
    chk("miss_data", rsp_data, 8'hEE);
    chk("miss_data_nodef", rsp_data0, 8'h00);
    lk_valid = 1'b1; lk_key = 4'd1; wr(4'd1, 8'h33); lk_valid = 1'b0;
    chk("rbw_old", rsp_data, 8'h11);
    lk(4'd1);
    chk("rbw_new", rsp_data, 8'h33);
    chk("rbw_occ", occupancy, 3'd2);
    tick();
    wr(4'd3, 8'h44);
    wr(4'd4, 8'h55);
    chk("full_4", full, 1'b1);
    wr(4'd5, 8'h66);
    chk("repl_occ", occupancy, 3'd4);
    lk(4'd1);
    chk("repl_k1_miss", rsp_hit, 1'b0);
    lk(4'd5);
    chk("repl_k5_idx", rsp_idx, 2'd0);
    chk("repl_k5_hit", rsp_hit, 1'b1);
    wr(4'd6, 8'h77);
    lk(4'd6);
    chk("repl_k6_idx", rsp_idx, 2'd1);
    tick();
    rsp_ready = 1'b0; lk_valid = 1'b1; lk_key = 4'd5;
    tick();
    lk_key = 4'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_lk_ready", lk_ready, 1'b0);
      chk("bp_hold_idx", rsp_idx, 2'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_idx", rsp_idx, 2'd1);
    lk_valid = 1'b0;
    tick();
    flush = 1'b1; wr(4'd7, 8'h88); flush = 1'b0;
    chk("flush_occ", occupancy, 3'd0);
    chk("flush_full", full, 1'b0);
    lk(4'd5); lk(4'd6); lk(4'd7);
    chk("flush_miss", rsp_hit, 1'b0);
    for (int i = 0; i < 60; i++) begin
      wr_en = $urandom_range(0, 1) == 1; wr_key = 4'($urandom_range(0, 7));
      wr_data = 8'($urandom); lk_valid = $urandom_range(0, 2) != 0;
      lk_key = 4'($urandom_range(0, 7)); rsp_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0; default_out = 8'($urandom);
      tick();
    end
    wr_en = 1'b0; flush = 1'b0; lk_valid = 1'b1; lk_key = 4'd1; rsp_ready = 1'b0;
    tick();
    chk("pre_rst_valid", rsp_valid, 1'b1);
    lk_valid = 1'b0; rst = 1'b1;
    tick();
    chk("rst_drop_valid", rsp_valid, 1'b0);
    rst = 1'b0; rsp_ready = 1'b1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
